// File: rtl/host_adapter_sequencer.sv
// SCSI host adapter sequencer: turns synchronised FC40-FC44 host strobes into
// ACK handshake, selection, bus reset and host interrupt timing.
//
// state       | meaning
// ACK_IDLE    | nACK released, waiting for an FC40 access with REQ asserted
// ACK_ASSERT  | nACK driven low until REQ releases or the ACK timer expires
// SEL_IDLE    | nSEL released
// SEL_SELECT  | nSEL low, waiting for target BSY or selection timeout
// SEL_HOLDING | target answered; nSEL held low for SEL_HOLD clocks
module host_adapter_sequencer #(
  parameter int SEL_TIMEOUT = 4096,
  parameter int SEL_HOLD    = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter int RST_PULSE   = 64
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic       nFC40RD,
  input  logic       nFC41RD,
  input  logic       nFC40WR,
  input  logic       nFC42WR,
  input  logic       nFC43WR,
  input  logic       nFC44WR,
  input  logic [7:0] bbc_DATA_IN,
  input  logic       scsi_nREQ,
  input  logic       scsi_nBSY,
  input  logic       scsi_nMSG,
  input  logic       scsi_nCD,
  input  logic       scsi_nIO,
  output logic       scsi_nACK,
  output logic       scsi_nSEL,
  output logic       scsi_nRST,
  output logic       nIRQ,
  output logic       dataLatch,
  output logic       scsiDataDrive,
  output logic [7:0] statusByte
);

  localparam int AW = $clog2(ACK_TIMEOUT);
  localparam int SW = $clog2(SEL_TIMEOUT);
  localparam int RW = $clog2(RST_PULSE);

  typedef enum logic {ACK_IDLE, ACK_ASSERT} ackState_t;
  typedef enum logic [1:0] {SEL_IDLE, SEL_SELECT, SEL_HOLDING} selState_t;

  // Inputs are idle-high, so synchronisers reset high to avoid phantom edges.
  logic [10:0] pinVec, sync1, sync2;
  logic [5:0]  strobePrev, strobeRise;

  assign pinVec = {scsi_nIO, scsi_nCD, scsi_nMSG, scsi_nBSY, scsi_nREQ,
                   nFC44WR, nFC43WR, nFC42WR, nFC41RD, nFC40WR, nFC40RD};

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      sync1      <= '1;
      sync2      <= '1;
      strobePrev <= '1;
    end else begin
      sync1      <= pinVec;
      sync2      <= sync1;
      strobePrev <= sync2[5:0];
    end
  end

  assign strobeRise = sync2[5:0] & ~strobePrev;

  logic fc40Event, fc41Event, fc42Event, fc43Event, rstEvent;
  logic req, bsy, msg, cd, io;

  assign fc40Event = strobeRise[0] | strobeRise[1];
  assign fc41Event = strobeRise[2];
  assign fc42Event = strobeRise[3];
  assign fc43Event = strobeRise[4];
  assign rstEvent  = strobeRise[5];
  assign dataLatch = strobeRise[1];

  assign req = ~sync2[6];
  assign bsy = ~sync2[7];
  assign msg = ~sync2[8];
  assign cd  = ~sync2[9];
  assign io  = ~sync2[10];

  ackState_t ackState, ackNext;
  selState_t selState, selNext;
  logic [AW-1:0] ackCnt, ackCntNext;
  logic [SW-1:0] selCnt, selCntNext;
  logic [RW-1:0] rstCnt;
  logic rstActive, ackToSet, selToSet, ackTo, selTo, irqEnable;

  always_comb begin
    ackNext    = ackState;
    ackCntNext = ackCnt;
    ackToSet   = 1'b0;
    if (rstEvent || rstActive) begin
      ackNext = ACK_IDLE;
    end else begin
      case (ackState)
        ACK_IDLE: if (fc40Event && req) begin
          ackNext    = ACK_ASSERT;
          ackCntNext = AW'(ACK_TIMEOUT - 1);
        end
        ACK_ASSERT: if (!req) begin
          ackNext = ACK_IDLE;
        end else if (ackCnt == '0) begin
          ackNext  = ACK_IDLE;
          ackToSet = 1'b1;
        end else begin
          ackCntNext = ackCnt - AW'(1);
        end
        default: ackNext = ACK_IDLE;
      endcase
    end
  end

  always_comb begin
    selNext    = selState;
    selCntNext = selCnt;
    selToSet   = 1'b0;
    if (rstEvent || rstActive) begin
      selNext = SEL_IDLE;
    end else begin
      case (selState)
        SEL_IDLE: if (fc42Event && !bsy) begin
          selNext    = SEL_SELECT;
          selCntNext = SW'(SEL_TIMEOUT - 1);
        end
        SEL_SELECT: if (bsy) begin
          selNext    = SEL_HOLDING;
          selCntNext = SW'(SEL_HOLD - 1);
        end else if (selCnt == '0) begin
          selNext  = SEL_IDLE;
          selToSet = 1'b1;
        end else begin
          selCntNext = selCnt - SW'(1);
        end
        SEL_HOLDING: if (selCnt == '0) begin
          selNext = SEL_IDLE;
        end else begin
          selCntNext = selCnt - SW'(1);
        end
        default: selNext = SEL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ackState <= ACK_IDLE;
      selState <= SEL_IDLE;
      ackCnt   <= '0;
      selCnt   <= '0;
    end else begin
      ackState <= ackNext;
      selState <= selNext;
      ackCnt   <= ackCntNext;
      selCnt   <= selCntNext;
    end
  end

  // A reset request during the pulse reloads the timer, stretching the pulse.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      rstActive <= 1'b0;
      rstCnt    <= '0;
    end else if (rstEvent) begin
      rstActive <= 1'b1;
      rstCnt    <= RW'(RST_PULSE - 1);
    end else if (rstActive) begin
      if (rstCnt == '0) rstActive <= 1'b0;
      else              rstCnt    <= rstCnt - RW'(1);
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ackTo         <= 1'b0;
      selTo         <= 1'b0;
      irqEnable     <= 1'b0;
      nIRQ          <= 1'b1;
      scsiDataDrive <= 1'b0;
    end else begin
      if (ackToSet)       ackTo <= 1'b1;
      else if (fc41Event) ackTo <= 1'b0;
      if (selToSet)       selTo <= 1'b1;
      else if (fc41Event) selTo <= 1'b0;
      if (fc43Event) irqEnable <= bbc_DATA_IN[0];
      nIRQ          <= ~(irqEnable & req & (ackState == ACK_IDLE) & ~rstActive);
      scsiDataDrive <= bsy & ~io;
    end
  end

  logic unusedData;
  assign unusedData = ^bbc_DATA_IN[7:1];

  assign scsi_nACK  = (ackState != ACK_ASSERT);
  assign scsi_nSEL  = (selState == SEL_IDLE);
  assign scsi_nRST  = ~rstActive;
  assign statusByte = {cd, io, req, irqEnable, ackTo, selTo, bsy, msg};

endmodule

// File: tb/tb_host_adapter_sequencer.sv
// Scoreboard bench for host_adapter_sequencer: stimulus queues expected output
// transitions (signal, value, cycle); a monitor matches every observed change.
module tb_host_adapter_sequencer;

  logic clock = 1'b0;
  logic nReset = 1'b0;
  logic nFC40RD = 1'b1, nFC41RD = 1'b1, nFC40WR = 1'b1;
  logic nFC42WR = 1'b1, nFC43WR = 1'b1, nFC44WR = 1'b1;
  logic [7:0] bbc_DATA_IN = 8'h00;
  logic scsi_nREQ = 1'b1, scsi_nBSY = 1'b1, scsi_nMSG = 1'b1;
  logic scsi_nCD = 1'b1, scsi_nIO = 1'b1;
  logic scsi_nACK, scsi_nSEL, scsi_nRST, nIRQ, dataLatch, scsiDataDrive;
  logic [7:0] statusByte;

  host_adapter_sequencer dut (
    .clock(clock), .nReset(nReset),
    .nFC40RD(nFC40RD), .nFC41RD(nFC41RD), .nFC40WR(nFC40WR),
    .nFC42WR(nFC42WR), .nFC43WR(nFC43WR), .nFC44WR(nFC44WR),
    .bbc_DATA_IN(bbc_DATA_IN),
    .scsi_nREQ(scsi_nREQ), .scsi_nBSY(scsi_nBSY), .scsi_nMSG(scsi_nMSG),
    .scsi_nCD(scsi_nCD), .scsi_nIO(scsi_nIO),
    .scsi_nACK(scsi_nACK), .scsi_nSEL(scsi_nSEL), .scsi_nRST(scsi_nRST),
    .nIRQ(nIRQ), .dataLatch(dataLatch), .scsiDataDrive(scsiDataDrive),
    .statusByte(statusByte)
  );

  always #5 clock = ~clock;

  localparam int S_ACK = 0, S_SEL = 1, S_RST = 2, S_IRQ = 3, S_DL = 4;
  localparam int FC40RD = 0, FC40WR = 1, FC41RD = 2, FC42WR = 3, FC43WR = 4, FC44WR = 5;

  typedef struct {int sig; logic val; int cyc;} exp_t;
  exp_t expQ[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic monOn = 1'b0;
  logic [4:0] prevOut;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string sigName(input int s);
    case (s)
      S_ACK:   return "scsi_nACK";
      S_SEL:   return "scsi_nSEL";
      S_RST:   return "scsi_nRST";
      S_IRQ:   return "nIRQ";
      default: return "dataLatch";
    endcase
  endfunction

  always @(negedge clock) begin
    logic [4:0] cur;
    int idx;
    if (monOn) begin
      cur = {dataLatch, nIRQ, scsi_nRST, scsi_nSEL, scsi_nACK};
      for (int i = 0; i < 5; i++) begin
        if (cur[i] !== prevOut[i]) begin
          idx = -1;
          foreach (expQ[j]) if (idx < 0 && expQ[j].sig == i) idx = j;
          vectors++;
          if (idx < 0) begin
            miscompares++;
            $display("FAIL %s: changed to %0b at cycle %0d, required no change", sigName(i), cur[i], cyc);
          end else begin
            if (expQ[idx].val !== cur[i] || expQ[idx].cyc != cyc) begin
              miscompares++;
              $display("FAIL %s: got %0b at cycle %0d, required %0b at cycle %0d",
                       sigName(i), cur[i], cyc, expQ[idx].val, expQ[idx].cyc);
            end
            expQ.delete(idx);
          end
        end
      end
      prevOut = cur;
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic pushExp(input int sig, input logic val, input int c);
    exp_t e;
    e.sig = sig; e.val = val; e.cyc = c;
    expQ.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic setStrobe(input int which, input logic v);
    case (which)
      FC40RD:  nFC40RD = v;
      FC40WR:  nFC40WR = v;
      FC41RD:  nFC41RD = v;
      FC42WR:  nFC42WR = v;
      FC43WR:  nFC43WR = v;
      default: nFC44WR = v;
    endcase
  endtask

  // Strobe low for two clocks; returns the cycle at which the pin rose.
  task automatic strobe(input int which, output int riseCyc);
    setStrobe(which, 1'b0);
    tick(2);
    setStrobe(which, 1'b1);
    riseCyc = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, q, s, b, p, p2, x;
    tick(3);
    nReset = 1'b1;
    tick(2);

    check("reset nACK", scsi_nACK, 1);
    check("reset nSEL", scsi_nSEL, 1);
    check("reset nRST", scsi_nRST, 1);
    check("reset nIRQ", nIRQ, 1);
    check("reset dataLatch", dataLatch, 0);
    check("reset scsiDataDrive", scsiDataDrive, 0);
    check("reset statusByte", statusByte, 8'h00);
    prevOut = {dataLatch, nIRQ, scsi_nRST, scsi_nSEL, scsi_nACK};
    monOn = 1'b1;

    // ACK handshake; first access with REQ idle must be ignored
    strobe(FC40RD, r);
    tick(4);
    scsi_nREQ = 1'b0;
    tick(4);
    check("status REQ", statusByte, 8'h20);
    strobe(FC40RD, r);
    pushExp(S_ACK, 1'b0, r + 3);
    tick(6);
    scsi_nREQ = 1'b1; q = cyc;
    pushExp(S_ACK, 1'b1, q + 3);
    tick(6);
    check("status idle after ack", statusByte, 8'h00);

    // ACK timeout via a data write
    scsi_nREQ = 1'b0;
    tick(4);
    strobe(FC40WR, r);
    pushExp(S_DL, 1'b1, r + 2);
    pushExp(S_DL, 1'b0, r + 3);
    pushExp(S_ACK, 1'b0, r + 3);
    pushExp(S_ACK, 1'b1, r + 3 + 1024);
    waitUntil(r + 1030);
    check("status ackTo", statusByte, 8'h28);
    strobe(FC41RD, s);
    tick(2);
    check("ackTo before clear", statusByte, 8'h28);
    tick(1);
    check("ackTo cleared", statusByte, 8'h20);
    scsi_nREQ = 1'b1;
    tick(4);
    check("status idle 2", statusByte, 8'h00);

    // Selection answered by target
    strobe(FC42WR, r);
    pushExp(S_SEL, 1'b0, r + 3);
    tick(6);
    scsi_nBSY = 1'b0; b = cyc;
    pushExp(S_SEL, 1'b1, b + 7);
    tick(10);
    check("status BSY", statusByte, 8'h02);
    check("drive BSY no IO", scsiDataDrive, 1);
    scsi_nIO = 1'b0;
    tick(4);
    check("status BSY IO", statusByte, 8'h42);
    check("drive BSY IO", scsiDataDrive, 0);
    scsi_nIO = 1'b1; scsi_nBSY = 1'b1;
    tick(4);
    check("status idle 3", statusByte, 8'h00);

    // Selection timeout
    strobe(FC42WR, r);
    pushExp(S_SEL, 1'b0, r + 3);
    pushExp(S_SEL, 1'b1, r + 3 + 4096);
    waitUntil(r + 4102);
    check("status selTo", statusByte, 8'h04);
    strobe(FC41RD, s);
    tick(2);
    check("selTo before clear", statusByte, 8'h04);
    tick(1);
    check("selTo cleared", statusByte, 8'h00);

    // IRQ enable and gating by ACK activity
    bbc_DATA_IN = 8'h01;
    strobe(FC43WR, r);
    tick(4);
    check("status irqEnable", statusByte, 8'h10);
    scsi_nREQ = 1'b0; q = cyc;
    pushExp(S_IRQ, 1'b0, q + 3);
    tick(6);
    check("status irq REQ", statusByte, 8'h30);
    strobe(FC40RD, r);
    pushExp(S_ACK, 1'b0, r + 3);
    pushExp(S_IRQ, 1'b1, r + 4);
    tick(6);
    scsi_nREQ = 1'b1; q = cyc;
    pushExp(S_ACK, 1'b1, q + 3);
    tick(6);
    bbc_DATA_IN = 8'h00;
    strobe(FC43WR, r);
    tick(4);
    check("status irq disabled", statusByte, 8'h00);
    scsi_nREQ = 1'b0;
    tick(8);
    check("status REQ no irq", statusByte, 8'h20);
    scsi_nREQ = 1'b1;
    tick(4);

    // Bus reset during selection, with a restart at clock 30 of the pulse
    strobe(FC42WR, r);
    pushExp(S_SEL, 1'b0, r + 3);
    tick(6);
    strobe(FC44WR, p);
    pushExp(S_RST, 1'b0, p + 3);
    pushExp(S_SEL, 1'b1, p + 3);
    tick(4);
    strobe(FC42WR, x);
    waitUntil(p + 28);
    strobe(FC44WR, p2);
    pushExp(S_RST, 1'b1, p2 + 67);
    waitUntil(p2 + 75);
    check("nSEL idle after reset", scsi_nSEL, 1);
    check("status after reset", statusByte, 8'h00);

    tick(10);
    foreach (expQ[j]) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no change seen, required %0b at cycle %0d",
               sigName(expQ[j].sig), expQ[j].val, expQ[j].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
